parallel_to_serial: RTL and testbench

- Byte-serialiser: accepts one BYTES×WIDTH-bit parallel word over a valid/ready handshake and emits it one WIDTH-bit symbol per accepted beat, lowest byte first.
- Transmit-side counterpart of the byte shift-in chain. The stream produced here, fed into that chain, leaves word byte k in stage Q(BYTES-1-k) after BYTES shifts.
- Sits between the word-wide datapath and the narrow byte link.

---
 rtl/parallel_to_serial_if.sv | 27 ++
 rtl/parallel_to_serial.sv | 97 +++++++++
 tb/tb_parallel_to_serial.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/parallel_to_serial_if.sv
// Load/serial-stream bundle for parallel_to_serial; q_par exists only with P2S_PARITY_EN.
interface parallel_to_serial_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BYTES = 8
);
  logic [WIDTH*BYTES-1:0] D;
  logic                   ld_valid;
  logic                   ld_ready;
  logic [WIDTH-1:0]       q_out;
  logic                   q_valid;
  logic                   q_ready;
  logic                   q_last;
  logic                   busy;
`ifdef P2S_PARITY_EN
  logic                   q_par;

  modport master (output D, ld_valid, q_ready,
                  input  ld_ready, q_out, q_valid, q_last, busy, q_par);
  modport slave  (input  D, ld_valid, q_ready,
                  output ld_ready, q_out, q_valid, q_last, busy, q_par);
`else
  modport master (output D, ld_valid, q_ready,
                  input  ld_ready, q_out, q_valid, q_last, busy);
  modport slave  (input  D, ld_valid, q_ready,
                  output ld_ready, q_out, q_valid, q_last, busy);
`endif
endinterface

// File: rtl/parallel_to_serial.sv
// Byte serialiser: loads a BYTES*WIDTH word and emits it lowest symbol first over valid/ready.
// Optional even-parity output q_par is enabled by defining P2S_PARITY_EN.
module parallel_to_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BYTES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  parallel_to_serial_if.slave  bus
);

  localparam int unsigned DATA_W = WIDTH * BYTES;
  localparam int unsigned IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state, state_n;
  logic [DATA_W-1:0]  shreg, shreg_n;
  logic [IDX_W-1:0]   byte_idx, byte_idx_n;
  logic [WIDTH-1:0]   q_out_r, q_out_n;
  logic               q_valid_r, q_valid_n;
  logic               q_last_r, q_last_n;
  logic               ld_ready_c;
  logic               xfer_c;
  logic               load_c;

  // State and datapath registers; reset discards any word in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      byte_idx  <= '0;
      q_out_r   <= '0;
      q_valid_r <= 1'b0;
      q_last_r  <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      byte_idx  <= byte_idx_n;
      q_out_r   <= q_out_n;
      q_valid_r <= q_valid_n;
      q_last_r  <= q_last_n;
    end
  end

  // Next-state: a load also covers the back-to-back case on the final beat
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    byte_idx_n = byte_idx;
    q_out_n    = q_out_r;
    q_valid_n  = q_valid_r;
    xfer_c     = q_valid_r && bus.q_ready;
    ld_ready_c = (state == IDLE) || (xfer_c && q_last_r);
    load_c     = bus.ld_valid && ld_ready_c;

    if (load_c) begin
      shreg_n    = bus.D;
      q_out_n    = bus.D[WIDTH-1:0];
      q_valid_n  = 1'b1;
      byte_idx_n = '0;
      state_n    = SEND;
    end else if ((state == SEND) && xfer_c) begin
      if (byte_idx != LAST_IDX) begin
        shreg_n    = shreg >> WIDTH;
        q_out_n    = shreg_n[WIDTH-1:0];
        byte_idx_n = byte_idx + IDX_W'(1);
      end else begin
        q_valid_n = 1'b0;
        q_out_n   = '0;
        state_n   = IDLE;
      end
    end

    q_last_n = q_valid_n && (byte_idx_n == LAST_IDX);
  end

  assign bus.ld_ready = ld_ready_c;
  assign bus.q_out    = q_out_r;
  assign bus.q_valid  = q_valid_r;
  assign bus.q_last   = q_last_r;
  assign bus.busy     = (state == SEND);

`ifdef P2S_PARITY_EN
  logic q_par_r;

  // q_out is zero whenever q_valid is low, so its parity is zero then too
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_par_r <= 1'b0;
    else        q_par_r <= ^q_out_n;
  end

  assign bus.q_par = q_par_r;
`endif

endmodule

// File: tb/tb_parallel_to_serial.sv
// Randomised and directed bench for parallel_to_serial against a queue-based reference model.
// Checks q_par as well when built with P2S_PARITY_EN.
module tb_parallel_to_serial;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned BYTES  = 8;
  localparam int unsigned DATA_W = WIDTH * BYTES;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] sent[$];
  logic [WIDTH-1:0] chain[BYTES];

  parallel_to_serial_if #(.WIDTH(WIDTH), .BYTES(BYTES)) bus ();

  parallel_to_serial #(.WIDTH(WIDTH), .BYTES(BYTES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare against the model, then advance the model past the edge
  task automatic cycle(input logic ldv, input logic [DATA_W-1:0] d, input logic qr);
    logic             exp_ldr;
    logic [WIDTH-1:0] exp_out;
    bus.ld_valid = ldv;
    bus.D        = d;
    bus.q_ready  = qr;
    #2;
    exp_out = '0;
    if (exp_q.size() > 0) exp_out = exp_q[0];
    exp_ldr = (exp_q.size() == 0) || ((exp_q.size() == 1) && qr);
    check("ld_ready", 64'(bus.ld_ready), 64'(exp_ldr));
    check("q_valid",  64'(bus.q_valid),  64'(exp_q.size() > 0));
    check("q_out",    64'(bus.q_out),    64'(exp_out));
    check("q_last",   64'(bus.q_last),   64'(exp_q.size() == 1));
    check("busy",     64'(bus.busy),     64'(exp_q.size() > 0));
`ifdef P2S_PARITY_EN
    check("q_par",    64'(bus.q_par),    64'(^exp_out));
`endif
    if ((exp_q.size() > 0) && qr) begin
      sent.push_back(bus.q_out);
      for (int i = BYTES - 1; i > 0; i--) chain[i] = chain[i-1];
      chain[0] = bus.q_out;
      void'(exp_q.pop_front());
    end
    if (ldv && exp_ldr)
      for (int k = 0; k < BYTES; k++) exp_q.push_back(d[k*WIDTH +: WIDTH]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] word_a;
    logic [DATA_W-1:0] word_b;
    logic [DATA_W-1:0] rnd;
    clk          = 1'b0;
    reset        = 1'b0;
    n_checks     = 0;
    n_errors     = 0;
    bus.D        = '0;
    bus.ld_valid = 1'b0;
    bus.q_ready  = 1'b0;
    for (int i = 0; i < BYTES; i++) chain[i] = '0;

    // Reset state
    #3;
    check("rst_q_valid", 64'(bus.q_valid), 64'd0);
    check("rst_q_out",   64'(bus.q_out),   64'd0);
    check("rst_q_last",  64'(bus.q_last),  64'd0);
    check("rst_busy",    64'(bus.busy),    64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    cycle(1'b0, '0, 1'b1);

    // Basic serialise
    sent.delete();
    cycle(1'b1, 64'h8877665544332211, 1'b1);
    for (int i = 0; i < BYTES + 2; i++) cycle(1'b0, '0, 1'b1);
    check("basic_count", 64'(sent.size()), 64'd8);
    for (int i = 0; i < sent.size(); i++)
      check("basic_byte", 64'(sent[i]), 64'(8'h11 * (i + 1)));

    // Backpressure with a 1,0,0 ready pattern
    sent.delete();
    cycle(1'b1, 64'h8877665544332211, 1'b0);
    for (int i = 0; i < 30; i++) cycle(1'b1, 64'hDEADBEEFCAFEF00D, (i % 3) == 0);
    for (int i = 0; i < BYTES * 2 + 2; i++) cycle(1'b0, '0, 1'b1);
    check("bp_first8_count", 64'(sent.size() >= 8), 64'd1);
    for (int i = 0; i < 8 && i < sent.size(); i++)
      check("bp_byte", 64'(sent[i]), 64'(8'h11 * (i + 1)));

    // Back-to-back words with no bubble
    sent.delete();
    word_a = 64'h0F0E0D0C0B0A0908;
    word_b = 64'h1716151413121110;
    cycle(1'b1, word_a, 1'b1);
    for (int i = 0; i < BYTES; i++) cycle(1'b1, word_b, 1'b1);
    for (int i = 0; i < BYTES + 2; i++) cycle(1'b0, '0, 1'b1);
    check("b2b_count", 64'(sent.size()), 64'd16);
    for (int i = 0; i < 16 && i < sent.size(); i++)
      check("b2b_byte", 64'(sent[i]), 64'(8 + i));

    // Loopback into the byte shift-in chain
    cycle(1'b1, 64'hF0E1D2C3B4A59687, 1'b1);
    for (int i = 0; i < BYTES + 1; i++) cycle(1'b0, '0, 1'b1);
    check("loop_q0", 64'(chain[0]), 64'hF0);
    check("loop_q7", 64'(chain[BYTES-1]), 64'h87);

    // Parity bytes 00,01,03,FF,80 (q_par checked by the model when enabled)
    cycle(1'b1, 64'h0000_0080_FF03_0100, 1'b1);
    for (int i = 0; i < BYTES + 1; i++) cycle(1'b0, '0, 1'b1);

    // Reset mid-word: three beats, then asynchronous reset
    cycle(1'b1, 64'h0807060504030201, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_q_valid", 64'(bus.q_valid), 64'd0);
    check("mid_rst_q_out",   64'(bus.q_out),   64'd0);
    check("mid_rst_busy",    64'(bus.busy),    64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom(), $urandom()};
      cycle(($urandom_range(0, 1) == 1), rnd, ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < BYTES * 2 + 2; i++) cycle(1'b0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
